// File: rtl/hex_page_display.sv
// hex_page_display: paged, blinking seven-segment hex view of a captured value,
// with leading-zero blanking and manual or timed page selection.
module hex_page_display #(
    parameter int DIGITS     = 6,
    parameter int DATA_W     = 32,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 50000000,
    localparam int NPAGES = (DATA_W + 4 * DIGITS - 1) / (4 * DIGITS),
    localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  hold,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    input  logic                  mode,
    input  logic                  page_next,
    output logic [7*DIGITS-1:0]   segs,
    output logic [PW-1:0]         page,
    output logic                  captured
);
    localparam int EXT_W = NPAGES * 4 * DIGITS;
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [DATA_W-1:0]   r_shadow;
    logic [7*DIGITS-1:0] r_segs;
    logic [PW-1:0]       r_page;
    logic                r_captured;
    logic [BW-1:0]       r_blink;
    logic [SW-1:0]       r_scroll;
    logic                r_phase;
    logic                r_pn_d;

    logic [EXT_W-1:0]    w_ext;
    logic [EXT_W-1:0]    w_sh;
    logic [7*DIGITS-1:0] w_segs;
    logic                w_blink_wrap;
    logic                w_scroll_wrap;
    logic                w_step;
    int                  w_idx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0011000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign w_ext         = EXT_W'(r_shadow);
    assign w_blink_wrap  = r_blink == BW'(BLINK_DIV - 1);
    assign w_scroll_wrap = r_scroll == SW'(SCROLL_DIV - 1);
    assign w_step        = mode ? w_scroll_wrap : (page_next && !r_pn_d);

    // A digit is blank when its nibble and all higher ones are zero, except nibble 0.
    always_comb begin
        w_segs = '1;
        w_idx  = 0;
        w_sh   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            w_idx = int'(r_page) * DIGITS + d;
            w_sh  = w_ext >> (4 * w_idx);
            if (!blank_lz || |w_sh || w_idx == 0) w_segs[7*d +: 7] = hex7(w_sh[3:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow   <= '0;
            r_segs     <= '1;
            r_page     <= '0;
            r_captured <= 1'b0;
            r_blink    <= '0;
            r_scroll   <= '0;
            r_phase    <= 1'b0;
            r_pn_d     <= 1'b0;
        end else begin
            r_pn_d     <= page_next;
            r_captured <= din_valid && !hold;
            if (din_valid && !hold) r_shadow <= din;
            r_scroll   <= (!mode || w_scroll_wrap) ? '0 : r_scroll + 1'b1;
            if (w_step && NPAGES > 1) r_page <= (r_page == PW'(NPAGES - 1)) ? '0 : r_page + 1'b1;
            r_blink    <= (!blink_en || w_blink_wrap) ? '0 : r_blink + 1'b1;
            r_phase    <= blink_en && (r_phase ^ w_blink_wrap);
            r_segs     <= (blink_en && r_phase) ? '1 : w_segs;
        end
    end

    assign segs     = r_segs;
    assign page     = r_page;
    assign captured = r_captured;
endmodule

// File: tb/tb_hex_page_display.sv
// tb_hex_page_display: directed vector table plus hand sequences for hold, blink, scroll, reset.
module tb_hex_page_display;
    localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100, C3 = 7'b0110000;
    localparam logic [6:0] C4 = 7'b0011001, C5 = 7'b0010010, C6 = 7'b0000010, C7 = 7'b1111000;
    localparam logic [6:0] C8 = 7'b0000000, C9 = 7'b0011000, CA = 7'b0001000, CB = 7'b0000011;
    localparam logic [6:0] CC = 7'b1000110, CD = 7'b0100001, CF = 7'b0001110, BL = 7'b1111111;

    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] din = '0;
    logic        din_valid = 0, hold = 0, blank_lz = 0, blink_en = 0, mode = 0, page_next = 0;
    logic [41:0] segs;
    logic [0:0]  page;
    logic        captured;

    int n_pass = 0, n_tot = 0;
    logic        tb_page = 0;
    logic [41:0] vis;

    typedef struct {
        logic [31:0] din;
        logic        lz;
        logic        pg;
        logic [41:0] segs;
    } vec_t;
    vec_t tv[13];

    hex_page_display #(.DIGITS(6), .DATA_W(32), .BLINK_DIV(4), .SCROLL_DIV(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .hold(hold),
        .blank_lz(blank_lz), .blink_en(blink_en), .mode(mode), .page_next(page_next),
        .segs(segs), .page(page), .captured(captured)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] pk(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_page();
        page_next = 1;
        tick();
        page_next = 0;
        tick();
        tb_page = ~tb_page;
    endtask

    initial begin
        tv[0]  = '{32'h1234ABCD, 1'b0, 1'b0, pk(C3, C4, CA, CB, CC, CD)};
        tv[1]  = '{32'h1234ABCD, 1'b0, 1'b1, pk(C0, C0, C0, C0, C1, C2)};
        tv[2]  = '{32'h1234ABCD, 1'b1, 1'b1, pk(BL, BL, BL, BL, C1, C2)};
        tv[3]  = '{32'h1234ABCD, 1'b1, 1'b0, pk(C3, C4, CA, CB, CC, CD)};
        tv[4]  = '{32'h00000000, 1'b1, 1'b0, pk(BL, BL, BL, BL, BL, C0)};
        tv[5]  = '{32'h00000000, 1'b0, 1'b0, pk(C0, C0, C0, C0, C0, C0)};
        tv[6]  = '{32'h00000000, 1'b1, 1'b1, pk(BL, BL, BL, BL, BL, BL)};
        tv[7]  = '{32'h000F0010, 1'b1, 1'b0, pk(BL, CF, C0, C0, C1, C0)};
        tv[8]  = '{32'h56789ABC, 1'b1, 1'b1, pk(BL, BL, BL, BL, C5, C6)};
        tv[9]  = '{32'h56789ABC, 1'b0, 1'b0, pk(C7, C8, C9, CA, CB, CC)};
        tv[10] = '{32'h00000001, 1'b1, 1'b0, pk(BL, BL, BL, BL, BL, C1)};
        tv[11] = '{32'h01000000, 1'b1, 1'b1, pk(BL, BL, BL, BL, BL, C1)};
        tv[12] = '{32'h10000000, 1'b1, 1'b0, pk(C0, C0, C0, C0, C0, C0)};

        tick();
        tick();
        chk("reset_segs", 64'(segs), 64'(42'h3FFFFFFFFFF));
        chk("reset_page", 64'(page), 0);
        chk("reset_captured", 64'(captured), 0);
        reset = 0;
        tick();
        chk("first_segs_zero", 64'(segs), 64'(pk(C0, C0, C0, C0, C0, C0)));

        for (int i = 0; i < 13; i++) begin
            blank_lz = tv[i].lz;
            if (tb_page != tv[i].pg) pulse_page();
            chk($sformatf("vec%0d_page", i), 64'(page), 64'(tb_page));
            din = tv[i].din;
            din_valid = 1;
            tick();
            din_valid = 0;
            chk($sformatf("vec%0d_captured", i), 64'(captured), 1);
            tick();
            chk($sformatf("vec%0d_segs", i), 64'(segs), 64'(tv[i].segs));
            chk($sformatf("vec%0d_captured_drop", i), 64'(captured), 0);
        end
        vis = tv[12].segs;

        hold = 1;
        din = 32'hFFFFFFFF;
        din_valid = 1;
        tick();
        din_valid = 0;
        chk("hold_captured", 64'(captured), 0);
        tick();
        tick();
        chk("hold_segs", 64'(segs), 64'(vis));

        page_next = 1;
        for (int k = 0; k < 5; k++) tick();
        tb_page = ~tb_page;
        chk("held_level_one_step", 64'(page), 64'(tb_page));
        page_next = 0;
        tick();
        vis = pk(BL, BL, BL, BL, C1, C0);
        chk("page_change_segs", 64'(segs), 64'(vis));

        blink_en = 1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk($sformatf("blink_%0d", k), 64'(segs), ((k - 1) / 4) % 2 ? 64'(42'h3FFFFFFFFFF) : 64'(vis));
        end
        blink_en = 0;
        tick();
        chk("blink_off_visible", 64'(segs), 64'(vis));
        tick();
        chk("blink_off_stays", 64'(segs), 64'(vis));
        hold = 0;

        if (tb_page) pulse_page();
        mode = 1;
        for (int k = 1; k <= 26; k++) begin
            page_next = k[1];
            tick();
            if (k % 8 == 0) tb_page = ~tb_page;
            chk($sformatf("scroll_%0d", k), 64'(page), 64'(tb_page));
        end
        page_next = 0;

        reset = 1;
        #1;
        chk("midreset_segs", 64'(segs), 64'(42'h3FFFFFFFFFF));
        chk("midreset_page", 64'(page), 0);
        tick();
        reset = 0;
        mode = 0;
        blank_lz = 1;
        tick();
        chk("post_reset_segs", 64'(segs), 64'(pk(BL, BL, BL, BL, BL, C0)));
        for (int k = 0; k < 12; k++) tick();
        chk("manual_no_scroll", 64'(page), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/hex_page_display.md
HEX_PAGE_DISPLAY -- requirements
Module: hex_page_display

Interface
REQ-001 The block SHALL have a parameter DIGITS, default 6: number of seven-segment digits driven.
REQ-002 The block SHALL have a parameter DATA_W, default 32: width of the displayed value.
REQ-003 The block SHALL have a parameter BLINK_DIV, default 25000000: clock cycles per blink half-period.
REQ-004 The block SHALL have a parameter SCROLL_DIV, default 50000000: clock cycles per auto-scroll page step.
REQ-005 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; one clock, all state on its rising edge.
- reset  in  1  asynchronous, active-high.
- din  in  DATA_W  value to display.
- din_valid  in  1  capture request.
- hold  in  1  freeze the display; capture is blocked while high.
- blank_lz  in  1  enable leading-zero blanking.
- blink_en  in  1  enable blinking.
- mode  in  1  page mode: 0 = manual, 1 = auto-scroll.
- page_next  in  1  manual page advance, level input.
- segs  out  7*DIGITS  active-low segments; digit d at [7d+6:7d]; bit 0 = segment a.
- page  out  PW  current page index.
- captured  out  1  one-cycle capture acknowledge.

Function
REQ-006 The block SHALL define NPAGES = ceil(DATA_W/(4*DIGITS)) and PW = max(1, clog2(NPAGES)).
REQ-007 The block SHALL zero-extend the stored value to NPAGES*4*DIGITS bits.
REQ-008 Page p digit d SHALL show nibble index p*DIGITS+d; digit 0 is least significant.
REQ-009 When din_valid=1 and hold=0, the block SHALL load din into the shadow register on that edge and assert captured for exactly the next cycle.
REQ-010 When din_valid=1 and hold=1, the block SHALL leave the shadow register unchanged and keep captured at 0.
REQ-011 segs SHALL be registered; a capture SHALL appear on segs 2 cycles after the din_valid edge (shadow stage + segment stage).
REQ-012 The hex-to-segment encoding SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0011000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
- blank = 1111111
REQ-013 With blank_lz=1, a digit SHALL be blank when it and every more significant nibble of the whole extended value are zero.
REQ-014 Nibble 0 on page 0 SHALL never be blanked, so value 0 shows "0".
REQ-015 Manual mode (mode=0): the block SHALL detect a rising edge on page_next internally; each edge SHALL advance page by 1, wrapping from NPAGES-1 to 0; a held level SHALL cause one step only.
REQ-016 Auto mode (mode=1): a scroll counter SHALL count 0..SCROLL_DIV-1 and advance page on wrap; page_next SHALL be ignored.
REQ-017 While mode=0, the scroll counter SHALL be held at 0.
REQ-018 When NPAGES=1, page SHALL remain 0 in both modes.
REQ-019 The blink counter SHALL count 0..BLINK_DIV-1 and toggle a phase bit on wrap while blink_en=1.
REQ-020 While blink_en=0, the blink counter and phase SHALL be held at 0, so blinking always starts in the visible phase.
REQ-021 While phase=1, all of segs SHALL be blank.
REQ-022 hold SHALL NOT stop page advance or blinking.
REQ-023 A page change SHALL appear on segs on the next cycle.

Reset
REQ-024 While reset=1, the block SHALL immediately force: segs all 1s, page=0, captured=0, shadow=0, both counters=0, phase=0, edge-detect register=0.
REQ-025 Reset asserted mid-scroll, mid-blink or during a capture SHALL discard the in-flight operation.
REQ-026 The first post-reset edge SHALL compute segs from shadow=0.

Verification (DIGITS=6, DATA_W=32, NPAGES=2)
REQ-027 Capture: din=0x1234ABCD, din_valid pulse, blank_lz=0, mode=0 -> captured high on cycle +1; on cycle +2, digits 0..5 show D,C,B,A,4,3; digit 0 = 0100001.
REQ-028 Page and blanking: page_next pulse -> page=1; digits 0..1 show D→2, 1; digits 2..5 show "0" with blank_lz=0 and 1111111 with blank_lz=1.
REQ-029 Hold: hold=1, din=0xFFFFFFFF with din_valid -> captured stays 0; segs unchanged.
REQ-030 Blink: BLINK_DIV=4, blink_en=1 -> segs visible 4 cycles, then all 1s 4 cycles, repeating; blink_en=0 -> visible next cycle.
REQ-031 Auto-scroll: SCROLL_DIV=8, mode=1 -> page toggles 0/1 every 8 cycles; page_next pulses have no effect.
REQ-032 Reset mid-operation: reset during auto-scroll with page=1 -> same-cycle segs all 1s, page=0; after release, segs show "0" on digit 0.
